// File: rtl/traffic_light_sequencer.sv
// Four-way traffic light sequencer with a one-second prescaler, pedestrian
// green shortening and an Avalon-MM control/status register block.
module traffic_light_sequencer #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        ped_req,
    output logic [2:0]  ns_lights,
    output logic [2:0]  ew_lights,
    output logic [3:0]  count_digit
);

    localparam int unsigned   PW           = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICK_DIV - 32'd1);
    localparam logic [11:0]   TIMES_RESET  = 12'h138;
    localparam logic [2:0]    LAMP_RED     = 3'b100;

    typedef enum logic [2:0] {
        ST_ALLRED_A  = 3'd0,
        ST_NS_GREEN  = 3'd1,
        ST_NS_YELLOW = 3'd2,
        ST_ALLRED_B  = 3'd3,
        ST_EW_GREEN  = 3'd4,
        ST_EW_YELLOW = 3'd5
    } state_t;

    function automatic logic [3:0] field_load(input logic [3:0] f);
        return (f == 4'd0) ? 4'd1 : f;
    endfunction

    function automatic logic [3:0] phase_time(input state_t s, input logic [11:0] t);
        logic [3:0] r;
        case (s)
            ST_NS_GREEN, ST_EW_GREEN:   r = field_load(t[3:0]);
            ST_NS_YELLOW, ST_EW_YELLOW: r = field_load(t[7:4]);
            default:                    r = field_load(t[11:8]);
        endcase
        return r;
    endfunction

    function automatic state_t next_phase(input state_t s);
        state_t n;
        case (s)
            ST_ALLRED_A:  n = ST_NS_GREEN;
            ST_NS_GREEN:  n = ST_NS_YELLOW;
            ST_NS_YELLOW: n = ST_ALLRED_B;
            ST_ALLRED_B:  n = ST_EW_GREEN;
            ST_EW_GREEN:  n = ST_EW_YELLOW;
            default:      n = ST_ALLRED_A;
        endcase
        return n;
    endfunction

    // Returns {ns, ew}; a disabled controller shows red both ways.
    function automatic logic [5:0] lamp_pattern(input state_t s, input logic en);
        logic [5:0] r;
        if (!en) begin
            r = {LAMP_RED, LAMP_RED};
        end else begin
            case (s)
                ST_NS_GREEN:  r = {3'b001, LAMP_RED};
                ST_NS_YELLOW: r = {3'b010, LAMP_RED};
                ST_EW_GREEN:  r = {LAMP_RED, 3'b001};
                ST_EW_YELLOW: r = {LAMP_RED, 3'b010};
                default:      r = {LAMP_RED, LAMP_RED};
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] sat_digit(input logic [3:0] r);
        return (r > 4'd9) ? 4'd9 : r;
    endfunction

    logic          enable_q,  enable_d;
    logic [11:0]   times_q,   times_d;
    state_t        state_q,   state_d;
    logic [3:0]    remaining_q, remaining_d;
    logic          ped_q,     ped_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic [2:0]    ns_q,      ns_d;
    logic [2:0]    ew_q,      ew_d;
    logic [3:0]    digit_q,   digit_d;

    logic   wr_s, ctrl_wr_s, times_wr_s, restart_s, tick_s;
    logic   valid_s, green_s, entry_s;
    state_t next_state_s;
    logic   unused_wdata_s;

    assign wr_s           = chipselect & ~write_n;
    assign ctrl_wr_s      = wr_s & (address == 2'd0);
    assign times_wr_s     = wr_s & (address == 2'd1);
    assign restart_s      = ctrl_wr_s & writedata[1];
    assign tick_s         = enable_q & (presc_q == '0);
    assign valid_s        = (state_q <= ST_EW_YELLOW);
    assign green_s        = (state_q == ST_NS_GREEN) || (state_q == ST_EW_GREEN);
    assign next_state_s   = next_phase(state_q);
    assign unused_wdata_s = ^writedata[31:12];

    // Next-state logic for registers, prescaler, phase sequencing and outputs.
    always_comb begin
        enable_d    = ctrl_wr_s ? writedata[0] : enable_q;
        times_d     = times_wr_s ? writedata[11:0] : times_q;
        state_d     = state_q;
        remaining_d = remaining_q;
        entry_s     = 1'b0;

        if (restart_s || !enable_q || tick_s) begin
            presc_d = PRESC_RELOAD;
        end else begin
            presc_d = presc_q - PW'(1);
        end

        // Restart and corrupted state codes both land in ALLRED_A immediately.
        if (restart_s || !valid_s) begin
            state_d     = ST_ALLRED_A;
            remaining_d = field_load(times_q[11:8]);
            entry_s     = 1'b1;
        end else if (tick_s) begin
            if (remaining_q <= 4'd1) begin
                state_d     = next_state_s;
                remaining_d = phase_time(next_state_s, times_q);
                entry_s     = 1'b1;
            end else if (green_s && ped_q && (remaining_q > 4'd2)) begin
                remaining_d = 4'd2;
            end else begin
                remaining_d = remaining_q - 4'd1;
            end
        end else begin
            remaining_d = remaining_q;
        end

        if (ped_req) begin
            ped_d = 1'b1;
        end else if (entry_s && ((state_d == ST_ALLRED_A) || (state_d == ST_ALLRED_B))) begin
            ped_d = 1'b0;
        end else begin
            ped_d = ped_q;
        end

        {ns_d, ew_d} = lamp_pattern(state_d, enable_d);
        digit_d      = sat_digit(remaining_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q    <= 1'b0;
            times_q     <= TIMES_RESET;
            state_q     <= ST_ALLRED_A;
            remaining_q <= 4'd1;
            ped_q       <= 1'b0;
            presc_q     <= PRESC_RELOAD;
            ns_q        <= LAMP_RED;
            ew_q        <= LAMP_RED;
            digit_q     <= 4'd1;
        end else begin
            enable_q    <= enable_d;
            times_q     <= times_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            ped_q       <= ped_d;
            presc_q     <= presc_d;
            ns_q        <= ns_d;
            ew_q        <= ew_d;
            digit_q     <= digit_d;
        end
    end

    // Zero-wait-state register read mux.
    always_comb begin
        case (address)
            2'd0:    readdata = {31'd0, enable_q};
            2'd1:    readdata = {20'd0, times_q};
            2'd2:    readdata = {24'd0, ped_q, remaining_q, state_q};
            default: readdata = 32'd0;
        endcase
    end

    assign ns_lights   = ns_q;
    assign ew_lights   = ew_q;
    assign count_digit = digit_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench for traffic_light_sequencer with a 4-cycle tick: expected
// phase/remaining/lamp values are queued per tick and compared at each tick edge.
module tb_traffic_light_sequencer;

    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ped_req;
    logic [2:0]  ns_lights;
    logic [2:0]  ew_lights;
    logic [3:0]  count_digit;

    traffic_light_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .ped_req     (ped_req),
        .ns_lights   (ns_lights),
        .ew_lights   (ew_lights),
        .count_digit (count_digit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [3:0] rem;
        logic       ped;
        logic       en;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   phase  = 0;
    logic en_m   = 1'b0;

    function automatic logic [5:0] exp_lamps(input logic [2:0] st, input logic en);
        logic [5:0] r;
        if (!en) begin
            r = 6'b100_100;
        end else begin
            case (st)
                3'd1:    r = 6'b001_100;
                3'd2:    r = 6'b010_100;
                3'd4:    r = 6'b100_001;
                3'd5:    r = 6'b100_010;
                default: r = 6'b100_100;
            endcase
        end
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        if (en_m) phase = (phase + 1) % TICK_DIV;
    endtask

    task automatic wait_tick();
        cycle();
        if (en_m) begin
            while (phase != 0) cycle();
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        address    = 2'd2;
        if (a == 2'd0) begin
            if (d[1] || (d[0] && !en_m) || !d[0]) phase = 0;
            en_m = d[0];
        end
        #1;
    endtask

    task automatic push(input int st, input int rem, input logic ped, input logic en);
        exp_t e;
        e.st  = 3'(st);
        e.rem = 4'(rem);
        e.ped = ped;
        e.en  = en;
        sb_q.push_back(e);
    endtask

    task automatic push_run(input int st, input int hi, input int lo, input logic ped);
        for (int r = hi; r >= lo; r--) push(st, r, ped, 1'b1);
    endtask

    // Pops one expectation and compares STATUS, both lamp sets and the digit.
    task automatic sb_check(input string tag);
        exp_t        e;
        logic [31:0] exp_status;
        logic [5:0]  lamps;
        logic [3:0]  exp_digit;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s sb_empty: got no expectation, required one", tag);
            return;
        end
        e          = sb_q.pop_front();
        exp_status = {24'd0, e.ped, e.rem, e.st};
        lamps      = exp_lamps(e.st, e.en);
        exp_digit  = (e.rem > 4'd9) ? 4'd9 : e.rem;
        if (readdata !== exp_status) begin
            errors++;
            $display("FAIL %s status: got %h required %h", tag, readdata, exp_status);
        end
        checks++;
        if (ns_lights !== lamps[5:3]) begin
            errors++;
            $display("FAIL %s ns_lights: got %b required %b", tag, ns_lights, lamps[5:3]);
        end
        checks++;
        if (ew_lights !== lamps[2:0]) begin
            errors++;
            $display("FAIL %s ew_lights: got %b required %b", tag, ew_lights, lamps[2:0]);
        end
        checks++;
        if (count_digit !== exp_digit) begin
            errors++;
            $display("FAIL %s count_digit: got %0d required %0d", tag, count_digit, exp_digit);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; address = 2'd2; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; ped_req = 1'b0;
        #23;
        push(0, 1, 1'b0, 1'b0);
        sb_check("reset");
        address = 2'd1; #1;
        checks++;
        if (readdata !== 32'h138) begin
            errors++;
            $display("FAIL reset_times: got %h required %h", readdata, 32'h138);
        end
        address = 2'd0; #1;
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %h required %h", readdata, 32'd0);
        end
        address = 2'd2;
        reset_n = 1'b1;
        cycle();
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'hFFFF_FFFF);
        address = 2'd3; #1;
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("FAIL addr3_read: got %h required %h", readdata, 32'd0);
        end
        address = 2'd2; #1;
        push(0, 1, 1'b0, 1'b0);
        sb_check("ro_write_ignored");
    endtask

    task automatic test_full_cycle();
        wr(2'd0, 32'd1);
        push(0, 1, 1'b0, 1'b1);
        sb_check("enable");
        push_run(1, 8, 1, 1'b0);
        push_run(2, 3, 1, 1'b0);
        push_run(3, 1, 1, 1'b0);
        push_run(4, 8, 1, 1'b0);
        push_run(5, 3, 1, 1'b0);
        push_run(0, 1, 1, 1'b0);
        repeat (24) begin
            wait_tick();
            sb_check("cycle");
        end
    endtask

    task automatic test_ped_shorten();
        push_run(1, 8, 6, 1'b0);
        repeat (3) begin
            wait_tick();
            sb_check("ped_pre");
        end
        ped_req = 1'b1;
        cycle();
        ped_req = 1'b0;
        push(1, 6, 1'b1, 1'b1);
        sb_check("ped_set");
        push_run(1, 2, 1, 1'b1);
        push_run(2, 3, 1, 1'b1);
        push(3, 1, 1'b0, 1'b1);
        repeat (6) begin
            wait_tick();
            sb_check("ped_short");
        end
    endtask

    task automatic test_times_midphase();
        push_run(4, 8, 1, 1'b0);
        push_run(5, 3, 1, 1'b0);
        push_run(0, 1, 1, 1'b0);
        push_run(1, 8, 8, 1'b0);
        repeat (13) begin
            wait_tick();
            sb_check("times_pre");
        end
        wr(2'd1, 32'h000);
        address = 2'd1; #1;
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("FAIL times_zero_read: got %h required %h", readdata, 32'd0);
        end
        address = 2'd2; #1;
        push_run(1, 7, 1, 1'b0);
        for (int s = 2; s <= 7; s++) push(s % 6, 1, 1'b0, 1'b1);
        push(2, 1, 1'b0, 1'b1);
        repeat (14) begin
            wait_tick();
            sb_check("times_zero");
        end
    endtask

    task automatic test_enable_freeze();
        wr(2'd1, 32'h138);
        push_run(3, 1, 1, 1'b0);
        push_run(4, 8, 1, 1'b0);
        push_run(5, 3, 2, 1'b0);
        repeat (11) begin
            wait_tick();
            sb_check("freeze_pre");
        end
        wr(2'd0, 32'd0);
        push(5, 2, 1'b0, 1'b0);
        sb_check("disabled");
        repeat (20) begin
            cycle();
            push(5, 2, 1'b0, 1'b0);
            sb_check("frozen");
        end
        wr(2'd0, 32'd1);
        push(5, 2, 1'b0, 1'b1);
        sb_check("reenable");
        push(5, 1, 1'b0, 1'b1);
        push(0, 1, 1'b0, 1'b1);
        push(1, 8, 1'b0, 1'b1);
        repeat (3) begin
            wait_tick();
            sb_check("resume");
        end
    endtask

    task automatic test_restart();
        push_run(1, 7, 1, 1'b0);
        push_run(2, 3, 1, 1'b0);
        push_run(3, 1, 1, 1'b0);
        push_run(4, 8, 8, 1'b0);
        repeat (12) begin
            wait_tick();
            sb_check("restart_pre");
        end
        wr(2'd1, 32'hF55);
        ped_req = 1'b1;
        cycle();
        ped_req = 1'b0;
        push(4, 8, 1'b1, 1'b1);
        sb_check("restart_ped");
        wr(2'd0, 32'd3);
        push(0, 15, 1'b0, 1'b1);
        sb_check("restart");
        address = 2'd0; #1;
        checks++;
        if (readdata !== 32'd1) begin
            errors++;
            $display("FAIL restart_ctrl_read: got %h required %h", readdata, 32'd1);
        end
        address = 2'd2; #1;
        push_run(0, 14, 1, 1'b0);
        push(1, 5, 1'b0, 1'b1);
        repeat (15) begin
            wait_tick();
            sb_check("long_allred");
        end
    endtask

    task automatic test_reset_midphase();
        push_run(1, 4, 1, 1'b0);
        push(2, 5, 1'b0, 1'b1);
        repeat (5) begin
            wait_tick();
            sb_check("rst_pre");
        end
        cycle();
        cycle();
        reset_n = 1'b0;
        #1;
        push(0, 1, 1'b0, 1'b0);
        sb_check("async_reset");
        address = 2'd1; #1;
        checks++;
        if (readdata !== 32'h138) begin
            errors++;
            $display("FAIL rst_times: got %h required %h", readdata, 32'h138);
        end
        address = 2'd3; #1;
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_addr3: got %h required %h", readdata, 32'd0);
        end
        address = 2'd2; #1;
        reset_n = 1'b1;
        en_m  = 1'b0;
        phase = 0;
        repeat (6) begin
            cycle();
            push(0, 1, 1'b0, 1'b0);
            sb_check("post_reset");
        end
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_ped_shorten();
        test_times_midphase();
        test_enable_freeze();
        test_restart();
        test_reset_midphase();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
